// File: rtl/serial_addsub_n_if.sv
// Operand/handshake/result bundle for the bit-serial adder/subtractor.
// master = operand source and result consumer; slave = the serial unit.
interface serial_addsub_n_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic             sum_bit;
  logic [WIDTH-1:0] out_sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output load, mode, data_a, data_b,
    input  busy, done, sum_bit, out_sum, carry_out, overflow
  );

  modport slave (
    input  load, mode, data_a, data_b,
    output busy, done, sum_bit, out_sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor. Operands are captured in parallel,
// one result bit is produced per clock LSB-first, and the completed word plus
// carry/overflow flags are published together with a one-cycle done pulse.
module serial_addsub_n #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  serial_addsub_n_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  // Only the upper WIDTH-1 partial-sum bits are kept: the bit that would fall
  // off the bottom on the final shift is never observable.
  logic [WIDTH-2:0] reg_s;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] out_sum;
  logic             carry_out;
  logic             overflow;

  logic             s_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] s_next;
  logic             last;

  // One full-adder slice on the current LSBs; subtraction arrives here as
  // A + ~B + 1 with the +1 preloaded into carry.
  assign s_bit     = reg_a[0] ^ reg_b[0] ^ carry;
  assign carry_nxt = (reg_a[0] & reg_b[0]) | (reg_a[0] & carry) | (reg_b[0] & carry);
  assign s_next    = {s_bit, reg_s};
  assign last      = (count == CW'(WIDTH - 1));

  // Capture / shift / publish sequencing; DONE may capture the next operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_s     <= '0;
      carry     <= 1'b0;
      count     <= '0;
      out_sum   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.load) begin
            reg_a <= bus.data_a;
            reg_b <= bus.mode ? ~bus.data_b : bus.data_b;
            carry <= bus.mode;
            count <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          carry <= carry_nxt;
          reg_a <= {1'b0, reg_a[WIDTH-1:1]};
          reg_b <= {1'b0, reg_b[WIDTH-1:1]};
          reg_s <= s_next[WIDTH-1:1];
          count <= count + 1'b1;
          if (last) begin
            out_sum   <= s_next;
            carry_out <= carry_nxt;
            // carry is the carry into the MSB on the last step
            overflow  <= carry ^ carry_nxt;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.sum_bit   = (state == SHIFT) & s_bit;
  assign bus.out_sum   = out_sum;
  assign bus.carry_out = carry_out;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n: WIDTH=4 unit checked every cycle against an
// arithmetic model, plus directed literal vectors at WIDTH 4, 8 and 2.
module tb_serial_addsub_n;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_addsub_n_if #(.WIDTH(4)) b4 ();
  serial_addsub_n_if #(.WIDTH(8)) b8 ();
  serial_addsub_n_if #(.WIDTH(2)) b2 ();

  serial_addsub_n #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  serial_addsub_n #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  serial_addsub_n #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  int n_vec = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (WIDTH=4) ----------------
  logic          m_active, m_done, m_co, m_ov, p_co, p_ov;
  logic [TW-1:0] m_sum, p_sum;
  int            m_step;

  // Result from plain integer arithmetic: {sum, carry/no-borrow, overflow}
  function automatic logic [TW+1:0] calc(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                         input logic m);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = m ? (ua - ub) : (ua + ub);
    sr = m ? (sa - sb) : (sa + sb);
    co = m ? (ua >= ub) : (ur >= (1 << TW));
    ov = (sr > (1 << (TW - 1)) - 1) || (sr < -(1 << (TW - 1)));
    return {ur[TW-1:0], co, ov};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_step   <= 0;
      m_sum    <= '0;
      m_co     <= 1'b0;
      m_ov     <= 1'b0;
      p_sum    <= '0;
      p_co     <= 1'b0;
      p_ov     <= 1'b0;
    end else if (m_active) begin
      m_step <= m_step + 1;
      if (m_step == TW - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_sum    <= p_sum;
        m_co     <= p_co;
        m_ov     <= p_ov;
      end
    end else begin
      m_done <= 1'b0;
      if (b4.load) begin
        m_active <= 1'b1;
        m_step   <= 0;
        {p_sum, p_co, p_ov} <= calc(b4.data_a, b4.data_b, b4.mode);
      end
    end
  end

  // Every-cycle comparison of the WIDTH=4 unit against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",      b4.busy,      m_active);
      chk("done",      b4.done,      m_done);
      chk("sum_bit",   b4.sum_bit,   m_active ? p_sum[m_step] : 1'b0);
      chk("out_sum",   b4.out_sum,   m_sum);
      chk("carry_out", b4.carry_out, m_co);
      chk("overflow",  b4.overflow,  m_ov);
    end
  end

  // ---------------- directed stimulus ----------------
  // All drives happen 1ns after a rising edge.
  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic m);
    b4.load = 1'b1; b4.data_a = a; b4.data_b = b; b4.mode = m;
    @(posedge clk); #1;
    b4.load = 1'b0; b4.data_a = 4'(($urandom)); b4.data_b = 4'($urandom);
  endtask

  task automatic finish4(input int pre, input logic [3:0] es, input logic eco, input logic eov);
    repeat (TW - pre) @(posedge clk);
    #1;
    chk("lit_done", b4.done, 1'b1);
    chk("lit_sum",  b4.out_sum, es);
    chk("lit_co",   b4.carry_out, eco);
    chk("lit_ov",   b4.overflow, eov);
    chk("model_sum", m_sum, es);
    chk("model_co",  m_co, eco);
    chk("model_ov",  m_ov, eov);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m,
                     input logic [3:0] es, input logic eco, input logic eov);
    @(posedge clk); #1;
    start4(a, b, m);
    finish4(0, es, eco, eov);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic eco, input logic eov);
    @(posedge clk); #1;
    b8.load = 1'b1; b8.data_a = a; b8.data_b = b; b8.mode = 1'b0;
    @(posedge clk); #1;
    b8.load = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("w8_early", b8.done, 1'b0);
    @(posedge clk); #1;
    chk("w8_done", b8.done, 1'b1);
    chk("w8_sum",  b8.out_sum, es);
    chk("w8_co",   b8.carry_out, eco);
    chk("w8_ov",   b8.overflow, eov);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1;
    b4.load = 0; b4.mode = 0; b4.data_a = 0; b4.data_b = 0;
    b8.load = 0; b8.mode = 0; b8.data_a = 0; b8.data_b = 0;
    b2.load = 0; b2.mode = 0; b2.data_a = 0; b2.data_b = 0;
    #1 reset = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Idle with moving data and no load
    for (int i = 0; i < 10; i++) begin
      b4.data_a = 4'($urandom); b4.data_b = 4'($urandom); b4.mode = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_busy", b4.busy, 1'b0);
    end
    chk("idle_sum", b4.out_sum, 4'h0);

    // Basic add, wrap/overflow, subtract
    op4(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0);
    op4(4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    op4(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
    op4(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    op4(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    op4(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
    op4(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
    op4(4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0);

    // load held high through two SHIFT edges with junk operands
    @(posedge clk); #1;
    b4.load = 1'b1; b4.data_a = 4'b0010; b4.data_b = 4'b0011; b4.mode = 1'b0;
    @(posedge clk); #1;
    b4.data_a = 4'b1111; b4.data_b = 4'b1111; b4.mode = 1'b1;
    repeat (2) @(posedge clk);
    #1 b4.load = 1'b0;
    finish4(2, 4'b0101, 1'b0, 1'b0);

    // Back-to-back: load in the DONE cycle, second done 5 cycles later
    start4(4'b0110, 4'b0011, 1'b0);
    chk("b2b_busy", b4.busy, 1'b1);
    finish4(0, 4'b1001, 1'b0, 1'b1);

    // Reset during SHIFT step 2 aborts the operation
    @(posedge clk); #1;
    start4(4'b0011, 4'b0011, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_busy", b4.busy, 1'b0);
    chk("rst_sum",  b4.out_sum, 4'h0);
    chk("rst_ov",   b4.overflow, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b4.done) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    op4(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);

    // Width sweep
    op8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    @(posedge clk); #1;
    b2.load = 1'b1; b2.data_a = 2'b01; b2.data_b = 2'b01; b2.mode = 1'b0;
    @(posedge clk); #1;
    b2.load = 1'b0;
    @(posedge clk); #1;
    chk("w2_early", b2.done, 1'b0);
    @(posedge clk); #1;
    chk("w2_done", b2.done, 1'b1);
    chk("w2_sum",  b2.out_sum, 2'b10);
    chk("w2_co",   b2.carry_out, 1'b0);
    chk("w2_ov",   b2.overflow, 1'b1);

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
